// File: rtl/mem_unit.sv
// Word-addressed data/instruction memory with req/ack handshake and programmable wait states.
// Optional read/write access counters are compiled in when MEM_STATS_EN is defined.
module mem_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign accept   = (state == S_IDLE) && req;
    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign idx      = addr_q[IDX_W-1:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = S_ACCESS;
                end
            end
            S_ACCESS: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Operands are latched only on accept, so requests seen while busy cannot disturb them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ack      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            ack <= 1'b0;
            if (accept) begin
                addr_q   <= addr;
                we_q     <= we;
                wdata_q  <= wdata;
                busy     <= 1'b1;
                wait_cnt <= WAIT_INIT;
            end
            if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == S_ACCESS) begin
                ack  <= 1'b1;
                busy <= 1'b0;
                err  <= !in_range;
                if (!in_range) begin
                    rdata <= '0;
                end else if (we_q) begin
                    rdata <= wdata_q;
                end else begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // The array has no reset; a reset forces IDLE so an aborted store never lands.
    always_ff @(posedge Clk) begin
        if (state == S_ACCESS && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (state == S_ACCESS && in_range) begin
            if (we_q) begin
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end else begin
                if (rd_count != 16'hFFFF) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: one instance with WAIT_CYCLES=1 (u1) and one with WAIT_CYCLES=0 (u0).
// Counter checks are compiled in when MEM_STATS_EN is defined.
module tb_mem_unit;

    logic Clk = 1'b0;
    logic Reset_n;

    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic [15:0] rdata0, rdata1;
    logic        ack0, ack1, busy0, busy1, err0, err1;
`ifdef MEM_STATS_EN
    logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run0 = 0;
    int run1 = 0;
    logic [15:0] vals [5] = '{16'h8001, 16'h0102, 16'h7FFF, 16'hFFFF, 16'h0000};

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    mem_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
`ifdef MEM_STATS_EN
        , .rd_count(rdc1), .wr_count(wrc1)
`endif
    );

    mem_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(0)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
`ifdef MEM_STATS_EN
        , .rd_count(rdc0), .wr_count(wrc0)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitors pop the scoreboard on every ack; an ack with nothing pending is itself a failure.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            run1 = 0;
        end else begin
            if (busy1) run1++;
            if (ack1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL u1 unexpected ack actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    checks--;
                    e = q1.pop_front();
                    check_output("u1 rdata", 32'(rdata1), 32'(e.rdata));
                    check_output("u1 err", 32'(err1), 32'(e.err));
                    check_output("u1 ack cycle", cyc, e.cyc);
                    check_output("u1 busy cycles", run1, 2);
                end
                run1 = 0;
            end
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            run0 = 0;
        end else begin
            if (busy0) run0++;
            if (ack0) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL u0 unexpected ack actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    checks--;
                    e = q0.pop_front();
                    check_output("u0 rdata", 32'(rdata0), 32'(e.rdata));
                    check_output("u0 err", 32'(err0), 32'(e.err));
                    check_output("u0 ack cycle", cyc, e.cyc);
                    check_output("u0 busy cycles", run0, 1);
                end
                run0 = 0;
            end
        end
    end

    task automatic wait_done(input int u);
        int pending;
        pending = 1;
        for (int i = 0; i < 20 && pending != 0; i++) begin
            @(negedge Clk);
            #1;
            pending = (u == 0) ? q0.size() : q1.size();
        end
        if (pending != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL u%0d ack timeout pending=%0d expected=0", u, pending);
            if (u == 0) q0.delete();
            else q1.delete();
        end
    endtask

    // Ack is due in the cycle after edge E0+WAIT+1, where E0 is the next rising edge.
    task automatic apply_stimulus(input int u, input logic w, input logic [7:0] a,
                                  input logic [15:0] d, input logic [15:0] er, input logic ee);
        exp_t e;
        @(negedge Clk);
        e.rdata = er;
        e.err   = ee;
        if (u == 1) begin
            e.cyc = cyc + 3;
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
            q1.push_back(e);
            @(negedge Clk);
            req1 = 1'b0;
        end else begin
            e.cyc = cyc + 2;
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
            q0.push_back(e);
            @(negedge Clk);
            req0 = 1'b0;
        end
        wait_done(u);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        exp_t e;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_output("reset ack", 32'(ack1), 0);
        check_output("reset busy", 32'(busy1), 0);
        check_output("reset err", 32'(err1), 0);
        check_output("reset rdata", 32'(rdata1), 0);
        check_output("reset u0 ack", 32'(ack0), 0);
        Reset_n = 1'b1;

        apply_stimulus(1, 1'b1, 8'd22, 16'd13, 16'd13, 1'b0);
        apply_stimulus(1, 1'b0, 8'd22, 16'd0, 16'd13, 1'b0);

        apply_stimulus(1, 1'b1, 8'd23, 16'hFFF8, 16'hFFF8, 1'b0);
        apply_stimulus(1, 1'b0, 8'd23, 16'h0000, 16'hFFF8, 1'b0);
        repeat (2) @(negedge Clk);
        check_output("rdata hold", 32'(rdata1), 32'h0000FFF8);
        check_output("ack low after pulse", 32'(ack1), 0);

        apply_stimulus(1, 1'b1, 8'd72, 16'h0072, 16'h0072, 1'b0);
        apply_stimulus(1, 1'b0, 8'd200, 16'h0000, 16'h0000, 1'b1);
        repeat (2) @(negedge Clk);
        check_output("err hold", 32'(err1), 1);
        apply_stimulus(1, 1'b1, 8'd200, 16'h1234, 16'h0000, 1'b1);
        apply_stimulus(1, 1'b0, 8'd72, 16'h0000, 16'h0072, 1'b0);

        // Back-to-back reads on the zero-wait unit with req held and junk operands while busy.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1'b1, 8'(10 + i), vals[i], vals[i], 1'b0);
        end
        @(negedge Clk);
        base = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            e.rdata = vals[i];
            e.err   = 1'b0;
            e.cyc   = base + 1 + 2 * i;
            q0.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 8'(10 + i); wdata0 = 16'h0000;
            @(negedge Clk);
            we0 = 1'b1; addr0 = 8'd99; wdata0 = 16'hDEAD;
            if (i == 4) req0 = 1'b0;
            @(negedge Clk);
        end
        wait_done(0);
        repeat (4) @(negedge Clk);

        apply_stimulus(1, 1'b1, 8'd5, 16'hAAAA, 16'hAAAA, 1'b0);
        @(negedge Clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'd5; wdata1 = 16'h5555;
        @(negedge Clk);
        req1 = 1'b0;
        check_output("busy before abort", 32'(busy1), 1);
        Reset_n = 1'b0;
        #1;
        check_output("abort ack", 32'(ack1), 0);
        check_output("abort busy", 32'(busy1), 0);
        check_output("abort err", 32'(err1), 0);
        check_output("abort rdata", 32'(rdata1), 0);
        repeat (3) @(negedge Clk);
        check_output("abort ack held", 32'(ack1), 0);
        Reset_n = 1'b1;
        apply_stimulus(1, 1'b0, 8'd5, 16'h0000, 16'hAAAA, 1'b0);

`ifdef MEM_STATS_EN
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        apply_stimulus(1, 1'b0, 8'd22, 16'h0000, 16'd13, 1'b0);
        apply_stimulus(1, 1'b0, 8'd23, 16'h0000, 16'hFFF8, 1'b0);
        apply_stimulus(1, 1'b0, 8'd72, 16'h0000, 16'h0072, 1'b0);
        apply_stimulus(1, 1'b1, 8'd30, 16'h0030, 16'h0030, 1'b0);
        apply_stimulus(1, 1'b1, 8'd31, 16'h0031, 16'h0031, 1'b0);
        apply_stimulus(1, 1'b0, 8'd250, 16'h0000, 16'h0000, 1'b1);
        check_output("rd_count", 32'(rdc1), 3);
        check_output("wr_count", 32'(wrc1), 2);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        check_output("rd_count reset", 32'(rdc1), 0);
        check_output("wr_count reset", 32'(wrc1), 0);
        Reset_n = 1'b1;
`endif

        repeat (5) @(negedge Clk);
        check_output("u1 pending", q1.size(), 0);
        check_output("u0 pending", q0.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
